// File: rtl/uoram_datapath_gen.sv
// UORAM frontend data path: routes one ORAM block at a time between the network,
// the PLB evict/refill ports and the backend store/load ports.
//   state | meaning
//   IDLE  | no request open, waiting for SwitchReq
//   XFER  | moving block beats for the latched mode until store/return are done
module uoram_datapath_gen #(
  parameter int          FEDWidth    = 64,
  parameter int          LeafWidth   = 32,
  parameter int          BlockChunks = 8,
  parameter int          EvictDepth  = 16,
  parameter logic [31:0] FakeWord    = 32'h00af1234
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 SwitchReq,
  input  logic                 DataBlockReq,
  input  logic [1:0]           Cmd,
  input  logic                 Dummy,
  output logic                 Busy,
  output logic                 ExpectingProgramData,
  output logic                 Error,
  output logic                 DataInReady,
  input  logic                 DataInValid,
  input  logic [FEDWidth-1:0]  DataIn,
  input  logic                 ReturnDataReady,
  output logic                 ReturnDataValid,
  output logic [FEDWidth-1:0]  ReturnData,
  output logic                 PPPEvictDataReady,
  input  logic                 PPPEvictDataValid,
  input  logic [LeafWidth-1:0] PPPEvictData,
  input  logic                 PPPRefillDataReady,
  output logic                 PPPRefillDataValid,
  output logic [LeafWidth-1:0] PPPRefillData,
  input  logic                 StoreDataReady,
  output logic                 StoreDataValid,
  output logic [FEDWidth-1:0]  StoreData,
  output logic                 LoadDataReady,
  input  logic                 LoadDataValid,
  input  logic [FEDWidth-1:0]  LoadData
);

  localparam int R   = FEDWidth / LeafWidth;
  localparam int CW  = $clog2(BlockChunks + 1);
  localparam int GW  = $clog2(R + 1);
  localparam int FCW = $clog2(EvictDepth + 1);
  localparam int AW  = (EvictDepth > 1) ? $clog2(EvictDepth) : 1;
  localparam logic [FEDWidth-1:0] FakeBeat = {(FEDWidth / 32){FakeWord}};

  typedef enum logic {S_IDLE, S_XFER} state_e;
  typedef enum logic [1:0] {M_PROG_ST, M_PROG_LD, M_FAKE, M_POSMAP} mode_e;

  state_e state_q, state_d;
  mode_e  mode_q, mode_d;
  logic   db_req_q, db_req_d;
  logic   st_req_q, st_req_d;
  logic   ret_req_q, ret_req_d;
  logic   err_q, err_d;
  logic [CW-1:0] st_cnt_q, st_cnt_d;
  logic [CW-1:0] ret_cnt_q, ret_cnt_d;

  logic [LeafWidth-1:0] fifo_mem_q [EvictDepth];
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FCW-1:0]       fifo_cnt_q, fifo_cnt_d;
  logic [FEDWidth-1:0]  gat_q, gat_d;
  logic [GW-1:0]        gat_cnt_q, gat_cnt_d, gat_base;
  logic [FEDWidth-1:0]  sct_q, sct_d;
  logic [GW-1:0]        sct_cnt_q, sct_cnt_d;

  logic busy, st_full, ret_full, gat_full, sct_empty, fifo_full, fifo_empty;
  logic st_fire, ret_fire, refill_fire, ev_push, ev_pop, gat_take, is_read;
  logic st_done_d, ret_done_d;
  int   gat_idx;

  assign busy       = (state_q == S_XFER);
  assign st_full    = (st_cnt_q == CW'(BlockChunks));
  assign ret_full   = (ret_cnt_q == CW'(BlockChunks));
  assign gat_full   = (gat_cnt_q == GW'(R));
  assign sct_empty  = (sct_cnt_q == '0);
  assign fifo_full  = (fifo_cnt_q == FCW'(EvictDepth));
  assign fifo_empty = (fifo_cnt_q == '0);
  assign is_read    = (Cmd == 2'd2) || (Cmd == 2'd3);

  assign Busy                 = busy;
  assign ExpectingProgramData = busy && db_req_q;
  assign Error                = err_q;

  // Per-mode routing of the store and return sides; all gated off outside XFER.
  always_comb begin
    DataInReady     = 1'b0;
    StoreDataValid  = 1'b0;
    StoreData       = '0;
    ReturnDataValid = 1'b0;
    ReturnData      = '0;
    LoadDataReady   = 1'b0;
    ret_fire        = 1'b0;
    if (busy) begin
      unique case (mode_q)
        M_PROG_ST: begin
          StoreData      = DataIn;
          StoreDataValid = DataInValid && !st_full;
          DataInReady    = StoreDataReady && !st_full;
        end
        M_PROG_LD: begin
          ReturnData      = LoadData;
          ReturnDataValid = LoadDataValid && !ret_full;
          LoadDataReady   = ReturnDataReady && !ret_full;
          ret_fire        = LoadDataValid && LoadDataReady;
        end
        M_FAKE: begin
          StoreData       = FakeBeat;
          StoreDataValid  = !st_full;
          ReturnData      = FakeBeat;
          ReturnDataValid = !ret_full;
          LoadDataReady   = 1'b1;
          ret_fire        = ReturnDataValid && ReturnDataReady;
        end
        M_POSMAP: begin
          StoreData      = gat_q;
          StoreDataValid = gat_full && !st_full;
          LoadDataReady  = sct_empty && !ret_full;
          ret_fire       = LoadDataValid && LoadDataReady;
        end
        default: ;
      endcase
    end
    st_fire = StoreDataValid && StoreDataReady;
  end

  // Evict FIFO feeding the gather; gather restarts on the cycle its beat is stored.
  always_comb begin
    PPPEvictDataReady = !fifo_full;
    ev_push    = PPPEvictDataValid && !fifo_full;
    gat_take   = st_fire && (mode_q == M_POSMAP);
    gat_base   = gat_take ? '0 : gat_cnt_q;
    ev_pop     = !fifo_empty && (gat_base < GW'(R));
    gat_d      = gat_take ? '0 : gat_q;
    gat_cnt_d  = gat_base;
    gat_idx    = int'(gat_base) * LeafWidth;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fifo_cnt_d = fifo_cnt_q;
    if (ev_pop) begin
      gat_d[gat_idx +: LeafWidth] = fifo_mem_q[rd_ptr_q];
      gat_cnt_d = gat_base + GW'(1);
      rd_ptr_d  = (rd_ptr_q == AW'(EvictDepth - 1)) ? '0 : rd_ptr_q + AW'(1);
    end
    if (ev_push) begin
      wr_ptr_d = (wr_ptr_q == AW'(EvictDepth - 1)) ? '0 : wr_ptr_q + AW'(1);
    end
    unique case ({ev_push, ev_pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + FCW'(1);
      2'b01:   fifo_cnt_d = fifo_cnt_q - FCW'(1);
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
  end

  // Refill scatter: one load beat in, R leaves out LSB-first.
  always_comb begin
    PPPRefillDataValid = !sct_empty;
    PPPRefillData      = sct_q[LeafWidth-1:0];
    refill_fire        = PPPRefillDataValid && PPPRefillDataReady;
    sct_d              = sct_q;
    sct_cnt_d          = sct_cnt_q;
    if (refill_fire) begin
      sct_d     = sct_q >> LeafWidth;
      sct_cnt_d = sct_cnt_q - GW'(1);
    end
    if (ret_fire && (mode_q == M_POSMAP)) begin
      sct_d     = LoadData;
      sct_cnt_d = GW'(R);
    end
  end

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    db_req_d   = db_req_q;
    st_req_d   = st_req_q;
    ret_req_d  = ret_req_q;
    st_cnt_d   = st_cnt_q;
    ret_cnt_d  = ret_cnt_q;
    err_d      = err_q;
    st_done_d  = 1'b0;
    ret_done_d = 1'b0;
    if (SwitchReq && busy) err_d = 1'b1;
    if (LoadDataValid && (!busy || (mode_q == M_PROG_ST))) err_d = 1'b1;
    if (DataInValid && !(busy && (mode_q == M_PROG_ST))) err_d = 1'b1;
    unique case (state_q)
      S_IDLE: begin
        if (SwitchReq) begin
          state_d  = S_XFER;
          db_req_d = DataBlockReq;
          if (!DataBlockReq)  mode_d = M_POSMAP;
          else if (!is_read)  mode_d = M_PROG_ST;
          else if (Dummy)     mode_d = M_FAKE;
          else                mode_d = M_PROG_LD;
          st_req_d  = (mode_d != M_PROG_LD);
          ret_req_d = (mode_d != M_PROG_ST);
          st_cnt_d  = '0;
          ret_cnt_d = '0;
        end
      end
      S_XFER: begin
        if (st_fire)  st_cnt_d  = st_cnt_q + CW'(1);
        if (ret_fire) ret_cnt_d = ret_cnt_q + CW'(1);
        st_done_d  = !st_req_q || (st_cnt_d == CW'(BlockChunks));
        ret_done_d = !ret_req_q || (ret_cnt_d == CW'(BlockChunks));
        // Leaves still in the scatter belong to this block, so hold XFER until drained.
        if (st_done_d && ret_done_d && (sct_cnt_d == '0)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (ev_push) fifo_mem_q[wr_ptr_q] <= PPPEvictData;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q    <= S_IDLE;
      mode_q     <= M_PROG_ST;
      db_req_q   <= 1'b0;
      st_req_q   <= 1'b0;
      ret_req_q  <= 1'b0;
      st_cnt_q   <= '0;
      ret_cnt_q  <= '0;
      err_q      <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      gat_q      <= '0;
      gat_cnt_q  <= '0;
      sct_q      <= '0;
      sct_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      db_req_q   <= db_req_d;
      st_req_q   <= st_req_d;
      ret_req_q  <= ret_req_d;
      st_cnt_q   <= st_cnt_d;
      ret_cnt_q  <= ret_cnt_d;
      err_q      <= err_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fifo_cnt_q <= fifo_cnt_d;
      gat_q      <= gat_d;
      gat_cnt_q  <= gat_cnt_d;
      sct_q      <= sct_d;
      sct_cnt_q  <= sct_cnt_d;
    end
  end

endmodule

// File: tb/tb_uoram_datapath_gen.sv
// Randomized bench for uoram_datapath_gen: transaction-level scoreboard of block
// beats per mode plus directed error, reset-state and mid-request reset cases.
module tb_uoram_datapath_gen;

  localparam int FW = 64;
  localparam int LW = 32;
  localparam int BC = 8;
  localparam int R  = FW / LW;
  localparam logic [FW-1:0] FAKE = 64'h00af123400af1234;
  localparam int CYC_LIMIT = 2000;

  logic          Clock, Reset, SwitchReq, DataBlockReq, Dummy;
  logic [1:0]    Cmd;
  logic          Busy, ExpectingProgramData, Error;
  logic          DataInReady, DataInValid;
  logic [FW-1:0] DataIn;
  logic          ReturnDataReady, ReturnDataValid;
  logic [FW-1:0] ReturnData;
  logic          PPPEvictDataReady, PPPEvictDataValid;
  logic [LW-1:0] PPPEvictData;
  logic          PPPRefillDataReady, PPPRefillDataValid;
  logic [LW-1:0] PPPRefillData;
  logic          StoreDataReady, StoreDataValid;
  logic [FW-1:0] StoreData;
  logic          LoadDataReady, LoadDataValid;
  logic [FW-1:0] LoadData;

  int n_cmp = 0;
  int n_bad = 0;

  uoram_datapath_gen #(
    .FEDWidth(FW), .LeafWidth(LW), .BlockChunks(BC), .EvictDepth(16),
    .FakeWord(32'h00af1234)
  ) dut (
    .Clock(Clock), .Reset(Reset), .SwitchReq(SwitchReq), .DataBlockReq(DataBlockReq),
    .Cmd(Cmd), .Dummy(Dummy), .Busy(Busy), .ExpectingProgramData(ExpectingProgramData),
    .Error(Error), .DataInReady(DataInReady), .DataInValid(DataInValid), .DataIn(DataIn),
    .ReturnDataReady(ReturnDataReady), .ReturnDataValid(ReturnDataValid),
    .ReturnData(ReturnData), .PPPEvictDataReady(PPPEvictDataReady),
    .PPPEvictDataValid(PPPEvictDataValid), .PPPEvictData(PPPEvictData),
    .PPPRefillDataReady(PPPRefillDataReady), .PPPRefillDataValid(PPPRefillDataValid),
    .PPPRefillData(PPPRefillData), .StoreDataReady(StoreDataReady),
    .StoreDataValid(StoreDataValid), .StoreData(StoreData), .LoadDataReady(LoadDataReady),
    .LoadDataValid(LoadDataValid), .LoadData(LoadData)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic chk_eq(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    SwitchReq = 0; DataBlockReq = 0; Cmd = 0; Dummy = 0;
    DataInValid = 0; DataIn = '0; ReturnDataReady = 0;
    PPPEvictDataValid = 0; PPPEvictData = '0; PPPRefillDataReady = 0;
    StoreDataReady = 0; LoadDataValid = 0; LoadData = '0;
  endtask

  task automatic do_reset();
    @(posedge Clock); #1;
    idle_inputs();
    Reset = 1;
    @(posedge Clock); #1;
    Reset = 0;
  endtask

  // mode: 0 program store, 1 program load, 2 dummy read, 3 posmap
  task automatic run_req(input logic db, input logic [1:0] cmd, input logic dmy, input bit inj_sw);
    logic [FW-1:0] di_q[$], ld_q[$], exp_st[$], exp_ret[$], st_obs[$], ret_obs[$];
    logic [LW-1:0] ev_q[$], exp_rf[$], rf_obs[$];
    logic [FW-1:0] w;
    logic [LW-1:0] lo, hi;
    int mode, cyc;
    bit done;
    mode = !db ? 3 : (cmd < 2 ? 0 : (dmy ? 2 : 1));
    for (int i = 0; i < BC; i++) begin
      w = {$urandom, $urandom};
      case (mode)
        0: begin di_q.push_back(w); exp_st.push_back(w); end
        1: begin ld_q.push_back(w); exp_ret.push_back(w); end
        2: begin exp_st.push_back(FAKE); exp_ret.push_back(FAKE); end
        default: begin
          lo = $urandom; hi = $urandom;
          ev_q.push_back(lo); ev_q.push_back(hi);
          exp_st.push_back({hi, lo});
          ld_q.push_back(w);
          exp_rf.push_back(w[LW-1:0]); exp_rf.push_back(w[FW-1:LW]);
        end
      endcase
    end
    @(posedge Clock); #1;
    SwitchReq = 1; DataBlockReq = db; Cmd = cmd; Dummy = dmy;
    @(negedge Clock);
    chk_eq("busy_at_req", Busy, 0);
    @(posedge Clock); #1;
    SwitchReq = 0;
    cyc = 0; done = 0;
    while (!done && cyc < CYC_LIMIT) begin
      DataInValid = (mode == 0) && (di_q.size() > 0) && ($urandom_range(0, 3) != 0);
      DataIn = (di_q.size() > 0) ? di_q[0] : '0;
      StoreDataReady = $urandom_range(0, 1);
      ReturnDataReady = ($urandom_range(0, 2) != 0);
      if (mode == 2) begin
        LoadDataValid = $urandom_range(0, 1);
        LoadData = {$urandom, $urandom};
      end else begin
        LoadDataValid = (mode != 0) && (ld_q.size() > 0) && ($urandom_range(0, 2) != 0);
        LoadData = (ld_q.size() > 0) ? ld_q[0] : '0;
      end
      PPPEvictDataValid = (mode == 3) && (ev_q.size() > 0) && ($urandom_range(0, 2) != 0);
      PPPEvictData = (ev_q.size() > 0) ? ev_q[0] : '0;
      PPPRefillDataReady = $urandom_range(0, 1);
      SwitchReq = inj_sw && (cyc == 3);
      DataBlockReq = inj_sw ? !db : db;
      @(negedge Clock);
      chk_eq("busy_in_xfer", Busy, 1);
      chk_eq("expect_prog", ExpectingProgramData, db);
      if (mode == 2) chk_eq("fake_load_ready", LoadDataReady, 1);
      if (mode == 1 && !ReturnDataReady) chk_eq("load_stall", LoadDataReady, 0);
      if (DataInValid && DataInReady) void'(di_q.pop_front());
      if (StoreDataValid && StoreDataReady) st_obs.push_back(StoreData);
      if (ReturnDataValid && ReturnDataReady) ret_obs.push_back(ReturnData);
      if (LoadDataValid && LoadDataReady && mode != 2) void'(ld_q.pop_front());
      if (PPPEvictDataValid && PPPEvictDataReady) void'(ev_q.pop_front());
      if (PPPRefillDataValid && PPPRefillDataReady) rf_obs.push_back(PPPRefillData);
      case (mode)
        0: done = (st_obs.size() >= BC);
        1: done = (ret_obs.size() >= BC);
        2: done = (st_obs.size() >= BC) && (ret_obs.size() >= BC);
        default: done = (st_obs.size() >= BC) && (ld_q.size() == 0) && (rf_obs.size() >= R * BC);
      endcase
      cyc++;
      @(posedge Clock); #1;
    end
    chk_eq("req_timeout", FW'(cyc < CYC_LIMIT), 1);
    idle_inputs();
    @(negedge Clock);
    chk_eq("busy_after_last", Busy, 0);
    chk_eq("error_flag", Error, FW'(inj_sw));
    chk_eq("store_count", st_obs.size(), exp_st.size());
    for (int i = 0; i < st_obs.size() && i < exp_st.size(); i++) chk_eq("store_data", st_obs[i], exp_st[i]);
    chk_eq("return_count", ret_obs.size(), exp_ret.size());
    for (int i = 0; i < ret_obs.size() && i < exp_ret.size(); i++) chk_eq("return_data", ret_obs[i], exp_ret[i]);
    chk_eq("refill_count", rf_obs.size(), exp_rf.size());
    for (int i = 0; i < rf_obs.size() && i < exp_rf.size(); i++) chk_eq("refill_data", FW'(rf_obs[i]), FW'(exp_rf[i]));
  endtask

  initial begin
    idle_inputs();
    Reset = 1;
    repeat (3) @(posedge Clock);
    #1 Reset = 0;
    @(negedge Clock);
    chk_eq("rst_busy", Busy, 0);
    chk_eq("rst_error", Error, 0);
    chk_eq("rst_evict_ready", PPPEvictDataReady, 1);
    chk_eq("rst_datain_ready", DataInReady, 0);
    chk_eq("rst_store_valid", StoreDataValid, 0);
    chk_eq("rst_return_valid", ReturnDataValid, 0);
    chk_eq("rst_refill_valid", PPPRefillDataValid, 0);
    chk_eq("rst_load_ready", LoadDataReady, 0);

    for (int rep = 0; rep < 3; rep++) begin
      run_req(1, 2'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
      run_req(1, 2'($urandom_range(2, 3)), 0, 0);
      run_req(1, 2'($urandom_range(2, 3)), 1, 0);
      run_req(0, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 0);
    end

    // SwitchReq while busy: flagged and ignored
    run_req(1, 0, 0, 1);
    do_reset();

    // stray load beat and network beat while idle
    LoadDataValid = 1; LoadData = 64'h1234;
    DataInValid = 1; DataIn = 64'h5678;
    @(negedge Clock);
    chk_eq("idle_load_ready", LoadDataReady, 0);
    chk_eq("idle_datain_ready", DataInReady, 0);
    chk_eq("idle_err_before", Error, 0);
    @(posedge Clock); #1;
    idle_inputs();
    @(negedge Clock);
    chk_eq("idle_err_after", Error, 1);
    do_reset();
    @(negedge Clock);
    chk_eq("err_cleared", Error, 0);

    // reset after 3 of 8 store beats
    @(posedge Clock); #1;
    SwitchReq = 1; DataBlockReq = 1; Cmd = 0;
    @(posedge Clock); #1;
    SwitchReq = 0; DataInValid = 1; StoreDataReady = 1;
    for (int i = 0; i < 3; i++) begin
      DataIn = FW'(i);
      @(posedge Clock); #1;
    end
    idle_inputs();
    Reset = 1;
    @(posedge Clock); #1;
    Reset = 0;
    @(negedge Clock);
    chk_eq("midrst_busy", Busy, 0);
    chk_eq("midrst_store_valid", StoreDataValid, 0);
    run_req(1, 0, 0, 0);
    run_req(0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uoram_datapath_gen.md
Name: uoram_datapath_gen

Overview:
- Parametrised successor of the UORAM frontend data path.
- Routes block data between the network program port, the PLB position-map evict/refill ports, and the ORAM backend store/load ports for one request at a time.
- Adds an explicit request FSM with busy/error reporting, independent store/return completion tracking, a generic LeafWidth↔FEDWidth gearbox, and a deterministic dummy-read mode.
- Sits between the UORAM frontend controller and PathORAMBackend.

Parameters:
FEDWidth, 64, backend/network beat width in bits
LeafWidth, 32, PLB leaf width; FEDWidth must be an integer multiple (R = FEDWidth/LeafWidth ≥ 1)
BlockChunks, 8, FEDWidth beats per ORAM block (≥ 2)
EvictDepth, 16, evict input FIFO depth in leaves (≥ R)
FakeWord, 32'h00af1234, 32-bit dummy pattern, replicated FEDWidth/32 times (FEDWidth multiple of 32)

Ports:
Clock  in  1  system clock
Reset  in  1  synchronous active-high reset
SwitchReq  in  1  request strobe, one cycle
DataBlockReq  in  1  1 = program data block, 0 = PosMap block
Cmd  in  2  0 Update, 1 Append, 2 Read, 3 ReadRmv
Dummy  in  1  read of non-existent block (valid with SwitchReq)
Busy  out  1  request in progress
ExpectingProgramData  out  1  Busy and program-data mode
Error  out  1  sticky protocol error
DataInReady/DataInValid/DataIn  out/in/in  1/1/FEDWidth  network → block
ReturnDataReady/ReturnDataValid/ReturnData  in/out/out  1/1/FEDWidth  block → network
PPPEvictDataReady/PPPEvictDataValid/PPPEvictData  out/in/in  1/1/LeafWidth  PLB → block
PPPRefillDataReady/PPPRefillDataValid/PPPRefillData  in/out/out  1/1/LeafWidth  block → PLB
StoreDataReady/StoreDataValid/StoreData  in/out/out  1/1/FEDWidth  block → backend
LoadDataReady/LoadDataValid/LoadData  out/in/in  1/1/FEDWidth  backend → block

Behaviour:
- Reset state:
  - FSM IDLE; counters, flags and gearboxes clear; evict FIFO empty.
  - Busy=0, Error=0.
  - All valid/ready outputs 0 except PPPEvictDataReady=1.
- Handshakes:
  - A transfer occurs on Valid&&Ready.
  - Valid is never dependent on Ready.
- IDLE:
  - SwitchReq latches DataBlockReq, Cmd and Dummy, and selects a mode.
  - The FSM enters XFER next cycle; Busy=1 from that cycle.
- Modes (StoreReq/RetReq = whether a BlockChunks store/return count must complete):
  - PROG_ST (data, Cmd 0/1), Store only:
    - StoreData=DataIn; StoreDataValid=DataInValid; DataInReady=StoreDataReady.
  - PROG_LD (data, Cmd 2/3, !Dummy), Return only:
    - ReturnData=LoadData; ReturnDataValid=LoadDataValid; LoadDataReady=ReturnDataReady.
  - FAKE (data, Cmd 2/3, Dummy), Store and Return:
    - StoreDataValid=1 with the fake pattern.
    - ReturnDataValid=1 with the fake pattern.
    - LoadDataReady=1; load beats are discarded and not counted.
  - POSMAP (DataBlockReq=0), Store and Return:
    - Store from the evict gather; return into the refill scatter.
- Counters: store and return counters run independently and saturate-flag at BlockChunks beats; further beats on a done side are not accepted (valid/ready gated low).
- XFER → IDLE: the cycle after the last required beat; Busy=0 that cycle. Store and return may finish in either order or on the same cycle.
- Evict path:
  - FIFO (EvictDepth) accepts leaves in any state; PPPEvictDataReady = !full.
  - Gather packs R leaves LSB-first into one FEDWidth beat.
  - StoreDataValid is asserted only in POSMAP with a full beat ready.
- Refill path:
  - Scatter accepts a LoadData beat when empty (LoadDataReady = scatter empty, POSMAP only).
  - Emits R leaves LSB-first on PPPRefill.
  - Return is counted at load acceptance.
  - In POSMAP, XFER completes only after the scatter has also drained.
- Errors (Error set; sticky until Reset):
  - SwitchReq while Busy: request ignored.
  - LoadDataValid in IDLE or PROG_ST: LoadDataReady=0.
  - DataInValid outside PROG_ST: DataInReady=0, no effect.
- Reset mid-request: returns to IDLE next cycle; partial beats, FIFO and gearboxes are dropped.

Test Plan:
1. FEDWidth=64, BlockChunks=8; SwitchReq Cmd=0, DataIn 8 beats 0..7 with StoreDataReady toggling → StoreData 0..7 in order; Busy falls the cycle after beat 7; Error=0.
2. Cmd=2, !Dummy; LoadData 8 beats with ReturnDataReady=0 for 3 cycles mid-burst → LoadDataReady=0 while stalled, no beat lost or duplicated.
3. Cmd=3, Dummy=1 → 8 StoreData and 8 ReturnData beats of 64'h00af123400af1234; stray LoadData beats are accepted and not forwarded.
4. POSMAP, LeafWidth=32; evict leaves A,B → StoreData {B,A}; LoadData 64'h2222_1111 → refill 1111 then 2222; Busy stays high until the 16th leaf is taken.
5. SwitchReq while Busy → Error=1, mode unchanged; LoadDataValid in IDLE → Error=1, LoadDataReady=0.
6. Reset asserted after 3 of 8 store beats → next cycle Busy=0, counters 0; a new request completes a full 8 beats.
